// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with single-outstanding imem handshake.
// Ports: clk/rst_n (sync, active-low); StallF/StallD/FlushD from hazard
//   unit; PCSrcE/PCTargetE redirect from execute; ImemReq/ImemAddr/
//   ImemReady request side; ImemRValid/ImemRData response side;
//   InstrD/PCD/PCPlus4D/ValidD IF/ID register.
// Option: define FETCH_PERF_CNT_EN to add FetchCount and DropCount.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemReady,
    input  logic        ImemRValid,
    input  logic [31:0] ImemRData,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] DropCount
`endif
);

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD
    } state_t;

    state_t      state;
    logic [31:0] pcf;
    logic [31:0] pco;
    logic [31:0] hold_instr;
    logic        drop;

    logic [31:0] target;
    logic        accept;
    logic        rsp_drop;
    logic        rsp_keep;
    logic        hold_drop;
    logic        load;
    logic [31:0] load_instr;
    logic        unused_tgt;

    // Redirect targets are word aligned; the low bits are ignored.
    assign target     = {PCTargetE[31:2], 2'b00};
    assign unused_tgt = ^PCTargetE[1:0];

    assign ImemReq  = rst_n && (state == REQ) && !StallF && !PCSrcE;
    assign ImemAddr = pcf;
    assign accept   = ImemReq && ImemReady;

    // A response is stale if a redirect arrived while it was in flight,
    // including a redirect in the very cycle the response shows up.
    assign rsp_drop  = (state == WAIT) && ImemRValid && (drop || PCSrcE);
    assign rsp_keep  = (state == WAIT) && ImemRValid && !drop && !PCSrcE;
    assign hold_drop = (state == HOLD) && PCSrcE;

    assign load = (rsp_keep && !StallD)
                || ((state == HOLD) && !PCSrcE && !StallD);
    assign load_instr = (state == HOLD) ? hold_instr : ImemRData;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= REQ;
            pcf        <= {RESET_PC[31:2], 2'b00};
            pco        <= '0;
            hold_instr <= '0;
            drop       <= 1'b0;
            InstrD     <= NOP_INSTR;
            PCD        <= '0;
            PCPlus4D   <= '0;
            ValidD     <= 1'b0;
        end else begin
            unique case (state)
                REQ: begin
                    if (PCSrcE) begin
                        pcf <= target;
                    end else if (accept) begin
                        pco   <= pcf;
                        pcf   <= pcf + 32'd4;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (PCSrcE) begin
                        pcf <= target;
                    end
                    if (rsp_drop) begin
                        drop  <= 1'b0;
                        state <= REQ;
                    end else if (rsp_keep) begin
                        if (StallD) begin
                            hold_instr <= ImemRData;
                            state      <= HOLD;
                        end else begin
                            state <= REQ;
                        end
                    end else if (PCSrcE) begin
                        drop <= 1'b1;
                    end
                end
                HOLD: begin
                    if (PCSrcE) begin
                        pcf   <= target;
                        state <= REQ;
                    end else if (!StallD) begin
                        state <= REQ;
                    end
                end
                default: state <= REQ;
            endcase

            if (FlushD) begin
                InstrD   <= NOP_INSTR;
                PCD      <= '0;
                PCPlus4D <= '0;
                ValidD   <= 1'b0;
            end else if (StallD) begin
                ValidD <= ValidD;
            end else if (load) begin
                InstrD   <= load_instr;
                PCD      <= pco;
                PCPlus4D <= pco + 32'd4;
                ValidD   <= 1'b1;
            end else begin
                InstrD   <= NOP_INSTR;
                PCD      <= '0;
                PCPlus4D <= '0;
                ValidD   <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            FetchCount <= '0;
            DropCount  <= '0;
        end else begin
            if (load && !FlushD) begin
                FetchCount <= FetchCount + 32'd1;
            end
            if (rsp_drop || hold_drop) begin
                DropCount <= DropCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus with a scoreboard for fetch_stage.
// Memory model returns data equal to address after a set latency.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemReady;
    logic        ImemRValid;
    logic [31:0] ImemRData;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] FetchCount, DropCount;
`endif

    fetch_stage dut (
        .clk(clk),
        .rst_n(rst_n),
        .StallF(StallF),
        .StallD(StallD),
        .FlushD(FlushD),
        .PCSrcE(PCSrcE),
        .PCTargetE(PCTargetE),
        .ImemReq(ImemReq),
        .ImemAddr(ImemAddr),
        .ImemReady(ImemReady),
        .ImemRValid(ImemRValid),
        .ImemRData(ImemRData),
        .InstrD(InstrD),
        .PCD(PCD),
        .PCPlus4D(PCPlus4D),
        .ValidD(ValidD)
`ifdef FETCH_PERF_CNT_EN
        ,
        .FetchCount(FetchCount),
        .DropCount(DropCount)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    // Memory model; deliberately not reset so a late response can
    // arrive after a mid-transaction reset.
    int unsigned lat = 1;
    int unsigned cnt = 0;
    logic [31:0] paddr = '0;

    assign ImemRValid = (cnt == 1);
    assign ImemRData  = paddr;

    always @(posedge clk) begin
        if (ImemReq && ImemReady) begin
            cnt   <= lat;
            paddr <= ImemAddr;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
        end
    end

    logic stalld_q = 1'b0;
    always @(posedge clk) stalld_q <= StallD;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor: a newly loaded IF/ID entry is one that is valid and was
    // not merely held by StallD at the last edge.
    always @(negedge clk) begin
        if (ValidD === 1'b1 && !stalld_q) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL sb_unexpected: got pc %h, expected none",
                         PCD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_instr", InstrD, e.instr);
                chk("sb_pcd", PCD, e.pc);
                chk("sb_pc4", PCPlus4D, e.pc4);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_one(input logic [31:0] a);
        exp_t e;
        chk("req", {31'd0, ImemReq}, 32'd1);
        chk("addr", ImemAddr, a);
        e.instr = a;
        e.pc    = a;
        e.pc4   = a + 32'd4;
        sb.push_back(e);
        step();
        chk("bubble", {31'd0, ValidD}, 32'd0);
        repeat (lat) step();
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0;
        StallF = 1'b0;
        StallD = 1'b0;
        FlushD = 1'b0;
        PCSrcE = 1'b0;
        PCTargetE = '0;
        ImemReady = 1'b1;
        repeat (2) step();

        chk("rst_req", {31'd0, ImemReq}, 32'd0);
        chk("rst_instr", InstrD, 32'h0000_0013);
        chk("rst_pcd", PCD, 32'd0);
        chk("rst_pc4", PCPlus4D, 32'd0);
        chk("rst_valid", {31'd0, ValidD}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_fcnt", FetchCount, 32'd0);
        chk("rst_dcnt", DropCount, 32'd0);
`endif
        rst_n = 1'b1;
        #1;

        fetch_one(32'h0);
        fetch_one(32'h4);

        StallF = 1'b1;
        #1;
        repeat (3) begin
            chk("stallf_req", {31'd0, ImemReq}, 32'd0);
            chk("stallf_addr", ImemAddr, 32'h8);
            step();
        end
        StallF = 1'b0;
        #1;
        fetch_one(32'h8);

        // StallD from the request cycle through one HOLD cycle.
        StallD = 1'b1;
        #1;
        chk("stall_req", {31'd0, ImemReq}, 32'd1);
        chk("stall_addr", ImemAddr, 32'hC);
        e.instr = 32'hC;
        e.pc    = 32'hC;
        e.pc4   = 32'h10;
        sb.push_back(e);
        step();
        chk("stall_pcd", PCD, 32'h8);
        chk("stall_valid", {31'd0, ValidD}, 32'd1);
        step();
        chk("hold_req", {31'd0, ImemReq}, 32'd0);
        chk("hold_pcd", PCD, 32'h8);
        StallD = 1'b0;
        step();

        // Redirect while the response is still in flight.
        lat = 2;
        chk("redir_req", {31'd0, ImemReq}, 32'd1);
        chk("redir_addr", ImemAddr, 32'h10);
        step();
        PCSrcE = 1'b1;
        PCTargetE = 32'h0000_0102;
        #1;
        chk("redir_noreq", {31'd0, ImemReq}, 32'd0);
        step();
        PCSrcE = 1'b0;
        chk("drop_wait_valid", {31'd0, ValidD}, 32'd0);
        step();
        chk("drop_valid", {31'd0, ValidD}, 32'd0);
        lat = 1;
        fetch_one(32'h100);

        // Flush and stall together on the response cycle.
        chk("flush_addr", ImemAddr, 32'h104);
        step();
        FlushD = 1'b1;
        StallD = 1'b1;
        step();
        FlushD = 1'b0;
        StallD = 1'b0;
        PCSrcE = 1'b1;
        PCTargetE = 32'hFFFF_FFFE;
        #1;
        chk("flush_instr", InstrD, 32'h0000_0013);
        chk("flush_valid", {31'd0, ValidD}, 32'd0);
        chk("flush_pcd", PCD, 32'd0);
        chk("flush_req", {31'd0, ImemReq}, 32'd0);
        step();
        PCSrcE = 1'b0;
        #1;
        fetch_one(32'hFFFF_FFFC);
        chk("wrap_addr", ImemAddr, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("fcnt", FetchCount, 32'd6);
        chk("dcnt", DropCount, 32'd2);
`endif

        // Reset with a request outstanding; its late response lands in REQ.
        lat = 2;
        step();
        rst_n = 1'b0;
        #1;
        chk("rst2_req", {31'd0, ImemReq}, 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("late_rvalid", {31'd0, ImemRValid}, 32'd1);
        fetch_one(32'h0);
        chk("post_rst_addr", ImemAddr, 32'h4);
`ifdef FETCH_PERF_CNT_EN
        chk("rst2_fcnt", FetchCount, 32'd1);
        chk("rst2_dcnt", DropCount, 32'd0);
`endif
        step();
        step();
        chk("sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
